// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth MULT and restoring DIV.
// Results are returned on HI/LO, with done and ErroDiv (divide by zero) pulses.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MultOrDiv,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             ErroDiv
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MULT: {p_hi, p_lo, q_m1} is the Booth accumulator, m is the sign-extended multiplicand.
  // DIV:  p_hi holds the partial remainder, p_lo shifts dividend out / quotient in, m is |B|.
  logic [WIDTH:0]     p_hi_q, p_hi_d;
  logic [WIDTH-1:0]   p_lo_q, p_lo_d;
  logic               q_m1_q, q_m1_d;
  logic [WIDTH:0]     m_q, m_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     booth_hi;
  logic [WIDTH-1:0]   booth_lo;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last_step;

  // Per-cycle datapath for one Booth step and one restoring-division step
  always_comb begin
    case ({p_lo_q[0], q_m1_q})
      2'b01:   booth_sum = p_hi_q + m_q;
      2'b10:   booth_sum = p_hi_q - m_q;
      default: booth_sum = p_hi_q;
    endcase
    booth_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_lo  = {booth_sum[0], p_lo_q[WIDTH-1:1]};

    div_shift = {p_hi_q[WIDTH-1:0], p_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, m_q[WIDTH-1:0]};
    div_diff  = div_shift[WIDTH-1:0] - m_q[WIDTH-1:0];
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo   = {p_lo_q[WIDTH-2:0], div_ge};

    abs_a     = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    abs_b     = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    q_m1_d    = q_m1_q;
    m_d       = m_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          p_hi_d    = '0;
          q_m1_d    = 1'b0;
          neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
          neg_rem_d = A[WIDTH-1];
          if (!MultOrDiv) begin
            p_lo_d  = B;
            m_d     = {A[WIDTH-1], A};
            state_d = ST_MULT;
            busy_d  = 1'b1;
          end else if (B == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            p_lo_d  = abs_a;
            m_d     = {1'b0, abs_b};
            state_d = ST_DIV;
            busy_d  = 1'b1;
          end
        end
      end
      ST_MULT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        p_hi_d = booth_hi;
        p_lo_d = booth_lo;
        q_m1_d = p_lo_q[0];
        if (last_step) begin
          hi_d    = booth_hi[WIDTH-1:0];
          lo_d    = booth_lo;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DIV: begin
        cnt_d  = cnt_q + CNT_W'(1);
        p_hi_d = {1'b0, div_rem};
        p_lo_d = div_quo;
        busy_d = 1'b1;
        if (last_step) state_d = ST_FIX;
      end
      ST_FIX: begin
        // Quotient sign from sign(A)^sign(B); remainder follows the dividend.
        lo_d    = neg_quo_q ? (~p_lo_q + WIDTH'(1)) : p_lo_q;
        hi_d    = neg_rem_q ? (~p_hi_q[WIDTH-1:0] + WIDTH'(1)) : p_hi_q[WIDTH-1:0];
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      q_m1_q    <= 1'b0;
      m_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      q_m1_q    <= q_m1_d;
      m_q       <= m_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ErroDiv = err_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mod = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, err;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .MultOrDiv(mod),
    .A(a), .B(b), .HI(hi), .LO(lo), .busy(busy), .done(done), .ErroDiv(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Signed arithmetic reference: 64-bit product, truncating division, remainder follows dividend
  task automatic model(input logic op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] old_hi, input logic [W-1:0] old_lo,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic eerr);
    longint sa, sb;
    logic [63:0] p;
    sa = $signed(ia);
    sb = $signed(ib);
    ehi = old_hi;
    elo = old_lo;
    eerr = 1'b0;
    if (!op) begin
      p = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else if (ib == '0) begin
      eerr = 1'b1;
    end else begin
      p = sa / sb;
      elo = p[31:0];
      p = sa % sb;
      ehi = p[31:0];
    end
  endtask

  // Issue one op, optionally re-pulse start at cycle 'glitch', and check the whole transaction
  task automatic run_op(input string nm, input logic op, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic eerr, input int glitch);
    int cyc, exp_lat;
    logic busy_ok;
    exp_lat = eerr ? 0 : (op ? 33 : 32);
    @(negedge clk);
    start = 1'b1; mod = op; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0; mod = ~op; a = $urandom; b = $urandom;
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 80) begin
      if (!busy) busy_ok = 1'b0;
      if (glitch != 0 && cyc == glitch) begin
        start = 1'b1; mod = ~op; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, " busy_during"}, 64'(busy_ok), 64'd1);
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " err"}, 64'(err), 64'(eerr));
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, " HI"}, 64'(hi), 64'(ehi));
    chk({nm, " LO"}, 64'(lo), 64'(elo));
    @(posedge clk); #1;
    chk({nm, " done_fall"}, 64'({done, err}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] m_hi, m_lo, ehi, elo, ra, rb;
    logic eerr, rop;

    tbl[0] = '{"mul_7x-3",   1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[1] = '{"mul_maxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    tbl[2] = '{"mul_minneg", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[3] = '{"div_7/-2",   1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[4] = '{"div_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[5] = '{"mul_shift",  1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    tbl[6] = '{"div_5/0",    1'b1, 32'h00000005, 32'h00000000, 32'h00000001, 32'h23456780, 1'b1};
    tbl[7] = '{"div_0/-9",   1'b1, 32'h00000000, 32'hFFFFFFF7, 32'h00000000, 32'h00000000, 1'b0};
    tbl[8] = '{"div_-7/2",   1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset HI", 64'(hi), 64'd0);
    chk("reset LO", 64'(lo), 64'd0);
    chk("reset flags", 64'({busy, done, err}), 64'd0);

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].err, 0);

    // A start pulse mid-DIV must be ignored
    run_op("div_ignore_start", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5);

    // Reset at cycle 10 of a DIV clears HI/LO immediately
    @(negedge clk);
    start = 1'b1; mod = 1'b1; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset HI", 64'(hi), 64'd0);
    chk("midreset LO", 64'(lo), 64'd0);
    chk("midreset flags", 64'({busy, done, err}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("mul_3x4_after_reset", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

    m_hi = 32'd0;
    m_lo = 32'd12;
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = '1;
        3: ra = 32'($urandom_range(0, 100));
        default: rb = $urandom;
      endcase
      if (i % 8 == 3) rb = $urandom;
      model(rop, ra, rb, m_hi, m_lo, ehi, elo, eerr);
      run_op($sformatf("rand%0d", i), rop, ra, rb, ehi, elo, eerr, 0);
      m_hi = ehi;
      m_lo = elo;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
